// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - md_op encodings (3 bits; 11x is a no-op)
//   - FSM state enum, also exported on the debug state port
package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the EX stage and the MDU.
//   master (EX stage): drives start, md_op, SrcA, SrcB, flush
//   slave  (MDU)     : drives busy, done, hi, lo
//
// Handshake: a request is taken on a rising edge where start=1, busy=0 and
// flush=0; md_op/SrcA/SrcB are sampled only on that edge. While busy=1 a
// start is ignored. done pulses for one cycle when a mult/div result lands in
// hi/lo, and a new start is accepted in that same cycle. flush aborts any
// in-flight operation and drops a coincident start.
interface mdu_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  start;
  logic [2:0]            md_op;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, md_op, SrcA, SrcB, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, md_op, SrcA, SrcB, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_sign_cond.sv
// mdu_sign_cond: conditional two's-complement negation.
//   i_val : value to condition
//   i_neg : 1 = negate, 0 = pass through
//   o_val : result
// Used as abs() on operand latch (i_neg = signed op and msb set) and as the
// sign fix-up of the unsigned result. abs(most-negative) yields the same bit
// pattern, which is the correct unsigned magnitude.
module mdu_sign_cond #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_val,
  input  logic                  i_neg,
  output logic [DATA_WIDTH-1:0] o_val
);
  assign o_val = i_neg ? (-i_val) : i_val;
endmodule

// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle MULT/MULTU/DIV/DIVU unit holding HI/LO.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : mdu_if slave (start/md_op/SrcA/SrcB/flush in;
//                 busy/done/hi/lo out)
//   o_dbg_state : current FSM state
// One shift-add (multiply) or shift-subtract (divide) step per CALC cycle,
// DATA_WIDTH steps, then one FIX cycle for sign correction and HI/LO write.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic       clk,
  input  logic       rst,
  mdu_if.slave       bus,
  output mdu_state_e o_dbg_state
);
  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(W - 1);

  mdu_state_e           r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_is_div;
  logic                 r_div0;
  logic                 r_neg_lo;   // product sign / quotient sign
  logic                 r_neg_hi;   // remainder sign
  logic [W-1:0]         r_srca;     // raw dividend, needed for divide-by-zero
  logic [W-1:0]         r_opb;      // multiplicand or divisor magnitude
  logic [2*W-1:0]       r_acc;      // mult: {upper, multiplier}; div: {rem, quot}
  logic [W-1:0]         r_hi, r_lo;
  logic                 r_done;
  logic                 w_busy;

  // Operand conditioning on accept
  logic         w_accept, w_signed, w_neg_a, w_neg_b;
  logic [W-1:0] w_abs_a, w_abs_b;

  assign w_accept = bus.start && !bus.flush && (r_state == ST_IDLE);
  assign w_signed = !bus.md_op[0];
  assign w_neg_a  = w_signed && bus.SrcA[W-1];
  assign w_neg_b  = w_signed && bus.SrcB[W-1];

  mdu_sign_cond #(.DATA_WIDTH(W)) u_abs_a (.i_val(bus.SrcA), .i_neg(w_neg_a), .o_val(w_abs_a));
  mdu_sign_cond #(.DATA_WIDTH(W)) u_abs_b (.i_val(bus.SrcB), .i_neg(w_neg_b), .o_val(w_abs_b));

  // Multiply step: W+1 bit sum keeps the carry, which becomes the new msb
  // after the right shift.
  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_nxt;
  assign w_mul_sum = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opb} : {(W+1){1'b0}});
  assign w_mul_nxt = {w_mul_sum, r_acc[W-1:1]};

  // Divide step: shifted remainder needs W+1 bits; after a successful
  // subtract the difference is below the divisor, so W bits suffice.
  logic [W:0]     w_rem_sh;
  logic [W-1:0]   w_rem_diff;
  logic           w_fits;
  logic [2*W-1:0] w_div_nxt;
  assign w_rem_sh   = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_fits     = (w_rem_sh >= {1'b0, r_opb});
  assign w_rem_diff = w_rem_sh[W-1:0] - r_opb;
  assign w_div_nxt  = w_fits ? {w_rem_diff,     r_acc[W-2:0], 1'b1}
                             : {w_rem_sh[W-1:0], r_acc[W-2:0], 1'b0};

  // Sign fix-up of the finished magnitude
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_quot, w_rem;
  mdu_sign_cond #(.DATA_WIDTH(2*W)) u_fix_prod (.i_val(r_acc), .i_neg(r_neg_lo), .o_val(w_prod));
  mdu_sign_cond #(.DATA_WIDTH(W)) u_fix_quot (.i_val(r_acc[W-1:0]),   .i_neg(r_neg_lo), .o_val(w_quot));
  mdu_sign_cond #(.DATA_WIDTH(W)) u_fix_rem  (.i_val(r_acc[2*W-1:W]), .i_neg(r_neg_hi), .o_val(w_rem));

  // Next-state and outputs
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept && !bus.md_op[2]) w_state_nxt = ST_CALC;
      ST_CALC: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_LAST) w_state_nxt = ST_FIX;
      end
      ST_FIX: begin
        w_busy      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (bus.flush) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_srca   <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (bus.flush) begin
        r_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (bus.start) begin
            case (bus.md_op)
              MD_MTHI: r_hi <= bus.SrcA;
              MD_MTLO: r_lo <= bus.SrcA;
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                r_cnt    <= '0;
                r_is_div <= bus.md_op[1];
                r_div0   <= (bus.SrcB == '0);
                r_neg_lo <= w_neg_a ^ w_neg_b;
                r_neg_hi <= w_neg_a;
                r_srca   <= bus.SrcA;
                r_opb    <= bus.md_op[1] ? w_abs_b : w_abs_a;
                r_acc    <= bus.md_op[1] ? {{W{1'b0}}, w_abs_a} : {{W{1'b0}}, w_abs_b};
              end
              default: ;
            endcase
          end
          ST_CALC: begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
            r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
          end
          ST_FIX: begin
            r_cnt  <= '0;
            r_done <= 1'b1;
            if (!r_is_div) begin
              {r_hi, r_lo} <= w_prod;
            end else if (r_div0) begin
              r_hi <= r_srca;
              r_lo <= '1;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mdu_iterative.sv
module tb_mdu_iterative;
  import mdu_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdu_if #(.DATA_WIDTH(W)) bus ();
  mdu_state_e dbg_state;

  mdu_iterative #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi = '0, m_lo = '0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural definition.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      MD_MULT: begin
        sp = longint'(sa) * longint'(sb);
        return sp;
      end
      MD_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      MD_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Monitor: compare every done pulse with the oldest expectation.
  logic [63:0] mon_exp;
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_unexpected: got done=1 with hi=%h lo=%h, required no done", bus.hi, bus.lo);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result_hi", 64'(bus.hi), 64'(mon_exp[63:32]));
        check("result_lo", 64'(bus.lo), 64'(mon_exp[31:0]));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.SrcA  = a;
    bus.SrcB  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.md_op = 3'b111;
    bus.SrcA  = $urandom;
    bus.SrcB  = $urandom;
  endtask

  // Issue a mult/div and wait for done; returns at the negedge of the done
  // cycle so a back-to-back start can be driven immediately.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int lat, busy_n;
    e = ref_md(op, a, b);
    exp_q.push_back(e);
    {m_hi, m_lo} = e;
    drive_start(op, a, b);
    lat = 0;
    busy_n = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.busy) busy_n++;
      @(posedge clk); #1;
    end
    check("latency", 64'(lat), 64'd34);
    check("busy_cycles", 64'(busy_n), 64'd33);
  endtask

  task automatic run_mt(input logic [2:0] op, input logic [31:0] v);
    drive_start(op, v, $urandom);
    if (op == MD_MTHI) m_hi = v;
    else               m_lo = v;
    @(negedge clk);
    check("mt_hi", 64'(bus.hi), 64'(m_hi));
    check("mt_lo", 64'(bus.lo), 64'(m_lo));
    check("mt_busy", 64'(bus.busy), 64'd0);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.done) n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nd;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int mode;

    bus.start = 1'b0;
    bus.md_op = 3'b111;
    bus.SrcA  = '0;
    bus.SrcB  = '0;
    bus.flush = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // Directed vectors; the second and later ones start in the done cycle.
    run_md(MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003);
    run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
    run_md(MD_DIVU,  32'h0000_0007, 32'h0000_0002);
    run_md(MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE);
    run_md(MD_DIV,   32'h0000_0005, 32'h0000_0000);
    run_md(MD_DIVU,  32'hFFFF_FFF0, 32'h0000_0000);
    run_md(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    @(posedge clk); #1;

    // No-op code: nothing changes.
    drive_start(3'b110, 32'hDEAD_BEEF, 32'h1);
    @(negedge clk);
    check("noop_hi", 64'(bus.hi), 64'(m_hi));
    check("noop_lo", 64'(bus.lo), 64'(m_lo));
    check("noop_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;

    // start together with flush is dropped.
    bus.flush = 1'b1;
    drive_start(MD_MULT, 32'd9, 32'd9);
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;

    // MTHI, then a MULT aborted by flush at CALC cycle 10 with a stray start.
    run_mt(MD_MTHI, 32'h1234_5678);
    run_mt(MD_MTLO, 32'h0BAD_F00D);
    @(posedge clk); #1;
    drive_start(MD_MULT, 32'h0000_1234, 32'h0000_5678);
    repeat (2) begin @(posedge clk); #1; end
    drive_start(MD_DIVU, 32'd100, 32'd3);      // ignored: busy
    repeat (6) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_hi", 64'(bus.hi), 64'h1234_5678);
    check("flush_lo", 64'(bus.lo), 64'(m_lo));
    count_done(45, nd);
    check("flush_no_done", 64'(nd), 64'd0);
    check("flush_hi_late", 64'(bus.hi), 64'h1234_5678);
    @(posedge clk); #1;

    // Reset during CALC cycle 5 of a DIVU.
    run_mt(MD_MTHI, 32'hA5A5_0001);
    run_mt(MD_MTLO, 32'h5A5A_0002);
    @(posedge clk); #1;
    drive_start(MD_DIVU, 32'd1000, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    check("rst_mid_hi", 64'(bus.hi), 64'd0);
    check("rst_mid_lo", 64'(bus.lo), 64'd0);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    count_done(40, nd);
    check("rst_no_done", 64'(nd), 64'd0);
    @(posedge clk); #1;
    run_md(MD_MULTU, 32'd3, 32'd4);
    @(posedge clk); #1;

    // Randomized mult/div, back to back.
    for (int i = 0; i < 24; i++) begin
      rop  = 3'($urandom_range(0, 3));
      ra   = $urandom;
      mode = $urandom_range(0, 9);
      case (mode)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: begin rb = $urandom; ra = 32'($urandom_range(0, 3)); end
        default: rb = $urandom;
      endcase
      run_md(rop, ra, rb);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("final_hi", 64'(bus.hi), 64'(m_hi));
    check("final_lo", 64'(bus.lo), 64'(m_lo));
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
